// File: rtl/tl_ul_buffer.sv
// TileLink-UL buffer stage: independent registered FIFOs on the A (core->fabric) and D (fabric->core) channels.
// Optional request limiter enabled by defining TL_UL_BUFFER_INFLIGHT_LIMIT_EN.

// Handshake rule for every port pair here: a beat transfers on a rising edge where valid & ready are both
// high; ready is a function of registered occupancy only, and valid never looks at the downstream ready.
module tl_ul_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             enq;
  logic             deq;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      if (enq && !deq)      count <= count + CW'(1);
      else if (deq && !enq) count <= count - CW'(1);
    end
  end

  // Payload storage carries no reset; stale entries are unreachable once the count is cleared.
  always_ff @(posedge clock) begin
    if (enq) mem[wr_ptr] <= in_data;
  end
endmodule

module tl_ul_buffer #(
  parameter int A_DEPTH      = 2,
  parameter int D_DEPTH      = 2,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int SRC_W        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  // core-side A
  input  logic                in_a_valid,
  output logic                in_a_ready,
  input  logic [2:0]          in_a_opcode,
  input  logic [2:0]          in_a_param,
  input  logic [1:0]          in_a_size,
  input  logic [SRC_W-1:0]    in_a_source,
  input  logic [ADDR_W-1:0]   in_a_address,
  input  logic [DATA_W/8-1:0] in_a_mask,
  input  logic [DATA_W-1:0]   in_a_data,
  // fabric-side A
  output logic                out_a_valid,
  input  logic                out_a_ready,
  output logic [2:0]          out_a_opcode,
  output logic [2:0]          out_a_param,
  output logic [1:0]          out_a_size,
  output logic [SRC_W-1:0]    out_a_source,
  output logic [ADDR_W-1:0]   out_a_address,
  output logic [DATA_W/8-1:0] out_a_mask,
  output logic [DATA_W-1:0]   out_a_data,
  // fabric-side D
  input  logic                out_d_valid,
  output logic                out_d_ready,
  input  logic [2:0]          out_d_opcode,
  input  logic [1:0]          out_d_param,
  input  logic [1:0]          out_d_size,
  input  logic [SRC_W-1:0]    out_d_source,
  input  logic                out_d_sink,
  input  logic                out_d_denied,
  input  logic                out_d_corrupt,
  input  logic [DATA_W-1:0]   out_d_data,
  // core-side D
  output logic                in_d_valid,
  input  logic                in_d_ready,
  output logic [2:0]          in_d_opcode,
  output logic [1:0]          in_d_param,
  output logic [1:0]          in_d_size,
  output logic [SRC_W-1:0]    in_d_source,
  output logic                in_d_sink,
  output logic                in_d_denied,
  output logic                in_d_corrupt,
  output logic [DATA_W-1:0]   in_d_data,
  output logic                idle
);
  localparam int AW = 3 + 3 + 2 + SRC_W + ADDR_W + DATA_W/8 + DATA_W;
  localparam int DW = 3 + 2 + 2 + SRC_W + 1 + 1 + 1 + DATA_W;
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;

  logic [AW-1:0] a_wdata;
  logic [AW-1:0] a_rdata;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          a_nonempty;
  logic          a_issue_ok;
  logic [IW-1:0] inflight;

  assign a_wdata = {in_a_opcode, in_a_param, in_a_size, in_a_source,
                    in_a_address, in_a_mask, in_a_data};
  assign {out_a_opcode, out_a_param, out_a_size, out_a_source,
          out_a_address, out_a_mask, out_a_data} = a_rdata;

  assign d_wdata = {out_d_opcode, out_d_param, out_d_size, out_d_source,
                    out_d_sink, out_d_denied, out_d_corrupt, out_d_data};
  assign {in_d_opcode, in_d_param, in_d_size, in_d_source,
          in_d_sink, in_d_denied, in_d_corrupt, in_d_data} = d_rdata;

  // The limiter gates both the visible valid and the dequeue so a stalled head is never popped.
  assign out_a_valid = a_nonempty & a_issue_ok;

  tl_ul_fifo #(.WIDTH(AW), .DEPTH(A_DEPTH)) u_a_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_a_valid),
    .in_ready  (in_a_ready),
    .in_data   (a_wdata),
    .out_valid (a_nonempty),
    .out_ready (out_a_ready & a_issue_ok),
    .out_data  (a_rdata)
  );

  tl_ul_fifo #(.WIDTH(DW), .DEPTH(D_DEPTH)) u_d_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (out_d_valid),
    .in_ready  (out_d_ready),
    .in_data   (d_wdata),
    .out_valid (in_d_valid),
    .out_ready (in_d_ready),
    .out_data  (d_rdata)
  );

`ifdef TL_UL_BUFFER_INFLIGHT_LIMIT_EN
  logic a_fire;
  logic d_fire;

  assign a_fire     = out_a_valid & out_a_ready;
  assign d_fire     = in_d_valid & in_d_ready;
  assign a_issue_ok = (inflight < IW'(MAX_INFLIGHT));

  // A response with nothing outstanding is a protocol error; hold at zero rather than wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= '0;
    end else if (a_fire && !d_fire) begin
      inflight <= inflight + IW'(1);
    end else if (d_fire && !a_fire && inflight != '0) begin
      inflight <= inflight - IW'(1);
    end
  end
`else
  assign a_issue_ok = 1'b1;
  assign inflight   = '0;
`endif

  assign idle = ~a_nonempty & ~in_d_valid & (inflight == '0);
endmodule
